// File: rtl/census_cost_pkg.sv
// Shared census-cost definitions: geometry derivations from the census window
// and disparity range, plus the scheduler FSM state encoding.
package census_cost_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  function automatic int unsigned nibit_f(input int unsigned wc);
    return (wc * wc) / 2;
  endfunction

  function automatic int unsigned nstages_f(input int unsigned wc);
    return $clog2(nibit_f(wc));
  endfunction

  function automatic int unsigned lat_f(input int unsigned wc);
    return nstages_f(wc) + 1;
  endfunction

  function automatic int unsigned cw_f(input int unsigned wc);
    return $clog2(nibit_f(wc) + 1);
  endfunction

  function automatic int unsigned dw_f(input int unsigned ndisp);
    return $clog2(ndisp);
  endfunction

endpackage

// File: rtl/wta_cost_sched_if.sv
// Pixel-in / result-out handshake bundle of the winner-take-all scheduler.
interface wta_cost_sched_if #(
  parameter int unsigned WC    = 7,
  parameter int unsigned NDISP = 16
);
  import census_cost_pkg::*;

  localparam int unsigned NIBIT = nibit_f(WC);
  localparam int unsigned CW    = cw_f(WC);
  localparam int unsigned DW    = dw_f(NDISP);

  logic [NDISP*NIBIT-1:0] i_xor_data;
  logic [DW-1:0]          i_dmax;
  logic                   i_valid;
  logic                   o_ready;
  logic                   o_valid;
  logic                   i_ready;
  logic [DW-1:0]          o_disp;
  logic [CW-1:0]          o_cost;
  logic                   o_busy;

  modport slave (
    input  i_xor_data, i_dmax, i_valid, i_ready,
    output o_ready, o_valid, o_disp, o_cost, o_busy
  );

  modport master (
    output i_xor_data, i_dmax, i_valid, i_ready,
    input  o_ready, o_valid, o_disp, o_cost, o_busy
  );

endinterface

// File: rtl/popcnt_pipe.sv
// Free-running pipelined popcount: input register plus NSTAGES adder levels,
// with a tag shift register of equal depth travelling alongside.
module popcnt_pipe
  import census_cost_pkg::*;
#(
  parameter  int unsigned WC    = 7,
  parameter  int unsigned TW    = 6,
  localparam int unsigned NIBIT = nibit_f(WC),
  localparam int unsigned CW    = cw_f(WC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NIBIT-1:0] data_i,
  input  logic [TW-1:0]    tag_i,
  output logic [CW-1:0]    cnt_o,
  output logic [TW-1:0]    tag_o
);

  localparam int unsigned NSTAGES = nstages_f(WC);
  localparam int unsigned LAT     = lat_f(WC);
  localparam int unsigned NLEAF   = 1 << NSTAGES;

  // Heap-ordered tree: node n sums nodes 2n and 2n+1; leaves are the input register.
  logic [CW-1:0]    node_q [1:2*NLEAF-1];
  logic [TW-1:0]    tag_q  [LAT];
  logic [NLEAF-1:0] pad;

  assign pad = NLEAF'(data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned n = 1; n < 2 * NLEAF; n++) node_q[n] <= '0;
      for (int unsigned s = 0; s < LAT; s++)       tag_q[s]  <= '0;
    end else begin
      for (int unsigned n = 1; n < NLEAF; n++)
        node_q[n] <= node_q[2*n] + node_q[2*n+1];
      for (int unsigned n = 0; n < NLEAF; n++)
        node_q[NLEAF+n] <= CW'(pad[n]);
      tag_q[0] <= tag_i;
      for (int unsigned s = 1; s < LAT; s++)
        tag_q[s] <= tag_q[s-1];
    end
  end

  assign cnt_o = node_q[1];
  assign tag_o = tag_q[LAT-1];

endmodule

// File: rtl/wta_cost_sched.sv
// Time-shares one popcount pipeline across the disparity candidates of a pixel
// and keeps the lowest-cost (lowest-index on ties) candidate as the result.
module wta_cost_sched
  import census_cost_pkg::*;
#(
  parameter int unsigned WC    = 7,
  parameter int unsigned NDISP = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  wta_cost_sched_if.slave bus
);

  localparam int unsigned NIBIT = nibit_f(WC);
  localparam int unsigned CW    = cw_f(WC);
  localparam int unsigned DW    = dw_f(NDISP);
  localparam int unsigned TW    = DW + 2;

  state_e           state_q;
  logic [DW-1:0]    k_q;
  logic [DW-1:0]    dmax_q;
  logic [DW-1:0]    min_disp_q;
  logic [CW-1:0]    min_cost_q;
  logic [NIBIT-1:0] slice_q [NDISP];

  logic [TW-1:0]    tag_in;
  logic [TW-1:0]    tag_out;
  logic [CW-1:0]    cnt;
  logic             res_vld;
  logic             res_last;
  logic [DW-1:0]    res_k;

  // Tag layout: {valid, candidate index, last-of-pixel}.
  assign tag_in = {state_q == S_ISSUE, k_q, k_q == dmax_q};
  assign {res_vld, res_k, res_last} = tag_out;

  popcnt_pipe #(
    .WC (WC),
    .TW (TW)
  ) u_popcnt (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .data_i (slice_q[k_q]),
    .tag_i  (tag_in),
    .cnt_o  (cnt),
    .tag_o  (tag_out)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      dmax_q     <= '0;
      min_disp_q <= '0;
      min_cost_q <= '0;
      for (int unsigned d = 0; d < NDISP; d++) slice_q[d] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            for (int unsigned d = 0; d < NDISP; d++)
              slice_q[d] <= bus.i_xor_data[d*NIBIT +: NIBIT];
            dmax_q  <= bus.i_dmax;
            k_q     <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          k_q <= k_q + 1'b1;
          if (k_q == dmax_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (res_vld && res_last) state_q <= S_OUT;
        end
        S_OUT: begin
          if (bus.i_ready) state_q <= S_IDLE;
        end
      endcase

      // Candidate 0 seeds the minimum; strict compare keeps the lowest index on ties.
      if ((state_q == S_ISSUE || state_q == S_DRAIN) && res_vld &&
          (res_k == '0 || cnt < min_cost_q)) begin
        min_cost_q <= cnt;
        min_disp_q <= res_k;
      end
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = (state_q == S_OUT);
  assign bus.o_busy  = (state_q != S_IDLE);
  assign bus.o_disp  = min_disp_q;
  assign bus.o_cost  = min_cost_q;

endmodule
